// File: rtl/gshare_predictor.sv
// gshare_predictor
//   Global-history (gshare) branch direction predictor. The fetch-side index is
//   PC[IDX_W+1:2] XOR the global history register (GHR). It selects a 2-bit
//   saturating counter in the pattern history table (PHT), and the counter MSB
//   is the taken/not-taken prediction. The fetch read is purely combinational.
//   Training comes from the execute-stage resolve port and is registered.
//
//   Configuration macro: GSHARE_SPEC_HIST_EN
//     undefined : the GHR shifts in the resolved direction on every resolve.
//     defined   : the GHR shifts in the prediction on each fetched branch.
//                 A mispredict restores the GHR from resolve_ghr plus the
//                 actual direction.
//
//   Ports
//     clk, rst        clock; asynchronous active-high reset
//     pc_fetch        fetch PC
//     fetch_valid     fetch advancing this cycle
//     btb_hit         fetch is a known branch
//     prediction      counter MSB at pred_idx (combinational)
//     pred_idx        PHT index used by this fetch
//     pred_ghr        GHR value used by this fetch
//     resolve_valid   a conditional branch resolved this cycle
//     resolve_taken   actual direction
//     resolve_mispr   direction was mispredicted (qualified by resolve_valid)
//     resolve_idx     pred_idx carried down the pipe with the branch
//     resolve_ghr     pred_ghr carried down the pipe with the branch
module gshare_predictor #(
    parameter int         GHR_W    = 8,
    parameter int         IDX_W    = 8,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_fetch,
    input  logic             fetch_valid,
    input  logic             btb_hit,
    output logic             prediction,
    output logic [IDX_W-1:0] pred_idx,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    input  logic             resolve_mispr,
    input  logic [IDX_W-1:0] resolve_idx,
    input  logic [GHR_W-1:0] resolve_ghr
);
    localparam int DEPTH = 1 << IDX_W;

    logic [GHR_W-1:0]      ghr_q, ghr_d;
    logic [DEPTH-1:0][1:0] pht_q, pht_d;
    logic [IDX_W-1:0]      ghr_ext;
    logic [1:0]            ctr_cur, ctr_nxt;

    // Zero-extend the GHR to index width. This also works when GHR_W == IDX_W.
    always_comb begin
        ghr_ext              = '0;
        ghr_ext[GHR_W-1:0]   = ghr_q;
    end

    assign pred_idx   = pc_fetch[IDX_W+1:2] ^ ghr_ext;
    // The fetch read comes straight from the flops. A same-cycle update to the
    // same entry becomes visible only on the next cycle.
    assign prediction = pht_q[pred_idx][1];
    assign pred_ghr   = ghr_q;

    // Saturating update of the counter being trained.
    assign ctr_cur = pht_q[resolve_idx];
    always_comb begin
        ctr_nxt = ctr_cur;
        if (resolve_taken) begin
            if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
        end
    end

    always_comb begin
        pht_d = pht_q;
        if (resolve_valid) pht_d[resolve_idx] = ctr_nxt;
    end

`ifdef GSHARE_SPEC_HIST_EN
    // A mispredict recovery wins over a same-cycle speculative shift, because
    // the fetch path that produced that shift is being flushed.
    always_comb begin
        ghr_d = ghr_q;
        if (resolve_valid && resolve_mispr)
            ghr_d = {resolve_ghr[GHR_W-2:0], resolve_taken};
        else if (fetch_valid && btb_hit)
            ghr_d = {ghr_q[GHR_W-2:0], prediction};
    end

    logic unused_bits;
    assign unused_bits = ^{pc_fetch[31:IDX_W+2], pc_fetch[1:0], resolve_ghr[GHR_W-1]};
`else
    // Non-speculative history: only resolved directions enter the GHR.
    always_comb begin
        ghr_d = ghr_q;
        if (resolve_valid) ghr_d = {ghr_q[GHR_W-2:0], resolve_taken};
    end

    logic unused_bits;
    assign unused_bits = ^{pc_fetch[31:IDX_W+2], pc_fetch[1:0], fetch_valid, btb_hit,
                           resolve_mispr, resolve_ghr};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
            pht_q <= {DEPTH{CTR_INIT}};
        end else begin
            ghr_q <= ghr_d;
            pht_q <= pht_d;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_fetch = 32'h0000_1234;
    logic        fetch_valid = 1'b0;
    logic        btb_hit = 1'b0;
    logic        prediction;
    logic [7:0]  pred_idx;
    logic [7:0]  pred_ghr;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic        resolve_mispr = 1'b0;
    logic [7:0]  resolve_idx = '0;
    logic [7:0]  resolve_ghr = '0;

    gshare_predictor #(.GHR_W(8), .IDX_W(8), .CTR_INIT(2'b01)) dut (
        .clk(clk), .rst(rst), .pc_fetch(pc_fetch), .fetch_valid(fetch_valid),
        .btb_hit(btb_hit), .prediction(prediction), .pred_idx(pred_idx),
        .pred_ghr(pred_ghr), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_mispr(resolve_mispr), .resolve_idx(resolve_idx), .resolve_ghr(resolve_ghr)
    );

    always #5 clk = ~clk;

    typedef struct { string tag; logic [31:0] val; } exp_t;
    exp_t       sb[$];
    int         n_assert = 0;
    int         n_fail = 0;
    logic [7:0] ghr_m;
    logic [1:0] pht_m [256];

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h, no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic model_reset();
        ghr_m = 8'h00;
        foreach (pht_m[i]) pht_m[i] = 2'b01;
    endtask

    // Point the fetch PC so that the hashed index lands on idx.
    task automatic fetch_at(input logic [7:0] idx);
        pc_fetch = {22'd0, idx ^ ghr_m, 2'b00};
        #1;
    endtask

    task automatic res_drive(input logic [7:0] idx, input logic tk, input logic mp,
                             input logic [7:0] rg);
        @(negedge clk);
        resolve_valid = 1'b1;
        resolve_idx   = idx;
        resolve_taken = tk;
        resolve_mispr = mp;
        resolve_ghr   = rg;
    endtask

    task automatic res_commit();
        @(posedge clk);
        if (resolve_taken && pht_m[resolve_idx] != 2'b11) pht_m[resolve_idx] = pht_m[resolve_idx] + 2'd1;
        if (!resolve_taken && pht_m[resolve_idx] != 2'b00) pht_m[resolve_idx] = pht_m[resolve_idx] - 2'd1;
`ifdef GSHARE_SPEC_HIST_EN
        if (resolve_mispr) ghr_m = {resolve_ghr[6:0], resolve_taken};
`else
        ghr_m = {ghr_m[6:0], resolve_taken};
`endif
        #1;
        resolve_valid = 1'b0;
        resolve_mispr = 1'b0;
    endtask

    task automatic resolve(input logic [7:0] idx, input logic tk);
        res_drive(idx, tk, 1'b0, 8'h00);
        res_commit();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        push("rst_ghr", 8'h00);   chk(pred_ghr);
        push("rst_pred", 1'b0);   chk(prediction);
        push("rst_idx", 8'h8D);   chk(pred_idx);
        @(negedge clk);
        rst = 1'b0;

        // Dirty some state, then reset mid-run
        resolve(8'h05, 1'b1);
        resolve(8'h05, 1'b1);
        fetch_at(8'h05);
        push("dirty_pred", 1'b1); chk(prediction);
        push("dirty_ghr", ghr_m); chk(pred_ghr);
        @(negedge clk);
        rst = 1'b1;
        pc_fetch = 32'h0000_0014;
        #1;
        model_reset();
        push("midrst_ghr", 8'h00); chk(pred_ghr);
        push("midrst_pred", 1'b0); chk(prediction);
        push("midrst_idx", 8'h05); chk(pred_idx);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            fetch_at(i[7:0]);
            push("init_pht", 1'b0); chk(prediction);
        end
        // One taken step from CTR_INIT crosses the MSB
        resolve(8'h77, 1'b1);
        fetch_at(8'h77);
        push("init_plus1", 1'b1); chk(prediction);

        // Counter training and saturation at both ends on idx 0x05
        pulse_reset();
        resolve(8'h05, 1'b1); fetch_at(8'h05); push("t1_10", 1'b1); chk(prediction);
        resolve(8'h05, 1'b1); fetch_at(8'h05); push("t2_11", 1'b1); chk(prediction);
        resolve(8'h05, 1'b1); fetch_at(8'h05); push("t3_sat11", 1'b1); chk(prediction);
        resolve(8'h05, 1'b0); fetch_at(8'h05); push("n1_10", 1'b1); chk(prediction);
        resolve(8'h05, 1'b0); fetch_at(8'h05); push("n2_01", 1'b0); chk(prediction);
        resolve(8'h05, 1'b0);
        resolve(8'h05, 1'b0);
        resolve(8'h05, 1'b1); fetch_at(8'h05); push("sat00_t_01", 1'b0); chk(prediction);
        resolve(8'h05, 1'b1); fetch_at(8'h05); push("sat00_t_10", 1'b1); chk(prediction);
        push("hist_after_train", ghr_m); chk(pred_ghr);

        // Hash with resolved history
        pulse_reset();
`ifndef GSHARE_SPEC_HIST_EN
        resolve(8'h40, 1'b1);
        resolve(8'h40, 1'b1);
        resolve(8'h40, 1'b0);
        pc_fetch = 32'h0000_0018;
        #1;
        push("hash_ghr", 8'h06); chk(pred_ghr);
        push("hash_idx", 8'h00); chk(pred_idx);
`endif

        // Same-cycle read/write of idx 0x10: pre-update value, then new value
        res_drive(8'h10, 1'b1, 1'b0, 8'h00);
        pc_fetch = {22'd0, 8'h10 ^ ghr_m, 2'b00};
        #1;
        push("same_cyc_old", 1'b0); chk(prediction);
        res_commit();
        fetch_at(8'h10);
        push("same_cyc_next", 1'b1); chk(prediction);

        // resolve_mispr without resolve_valid is ignored
        @(negedge clk);
        resolve_mispr = 1'b1;
        resolve_ghr   = 8'hAA;
        resolve_idx   = 8'h10;
        resolve_taken = 1'b0;
        @(posedge clk);
        #1;
        resolve_mispr = 1'b0;
        push("mispr_novld_ghr", ghr_m); chk(pred_ghr);
        fetch_at(8'h10);
        push("mispr_novld_pht", 1'b1); chk(prediction);

`ifndef GSHARE_SPEC_HIST_EN
        // Fetched branches do not move the history
        @(negedge clk);
        fetch_at(8'h10);
        fetch_valid = 1'b1;
        btb_hit     = 1'b1;
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        btb_hit     = 1'b0;
        push("fetch_no_ghr", ghr_m); chk(pred_ghr);
`else
        // Speculative shift on a predicted-taken fetch
        pulse_reset();
        resolve(8'h20, 1'b1);
        resolve(8'h20, 1'b1);
        push("spec_noshift_resolve", 8'h00); chk(pred_ghr);
        @(negedge clk);
        pc_fetch    = 32'h0000_0080;
        fetch_valid = 1'b1;
        btb_hit     = 1'b1;
        #1;
        push("spec_pred", 1'b1); chk(prediction);
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        btb_hit     = 1'b0;
        ghr_m       = 8'h01;
        push("spec_shift", 8'h01); chk(pred_ghr);
        @(negedge clk);
        fetch_valid = 1'b1;
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        push("spec_no_btb", 8'h01); chk(pred_ghr);
        // Recovery wins over a concurrent speculative shift
        res_drive(8'h33, 1'b0, 1'b1, 8'h0F);
        fetch_valid = 1'b1;
        btb_hit     = 1'b1;
        res_commit();
        fetch_valid = 1'b0;
        btb_hit     = 1'b0;
        push("spec_recover", 8'h1E); chk(pred_ghr);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
